// File: rtl/mii_frame_pkg.sv
// rtl/mii_frame_pkg.sv - shared state encoding, framing nibbles and CRC-32 constants/helpers
package mii_frame_pkg;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_e;

  localparam logic [3:0]  PREAMBLE_NIB  = 4'h5;
  localparam logic [3:0]  SFD_NIB       = 4'hD;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// rtl/eth_crc32.sv - byte-wide reflected CRC-32 register with clear and enable
module eth_crc32
  import mii_frame_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = crc32_byte(crc_q, data_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= CRC_INIT;
    else     crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/mii_frame_rx.sv
// rtl/mii_frame_rx.sv - MII nibble receiver: preamble/SFD strip, byte assembly, length/FCS checks
// Optional FCS checking is built when MII_FRAME_RX_CRC_CHECK_EN is defined.
module mii_frame_rx
  import mii_frame_pkg::*;
#(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mii_dv,
  input  logic [3:0]  mii_data,
  output logic [7:0]  byte_o,
  output logic        byte_valid,
  output logic        sof,
  output logic        eof,
  output logic [10:0] frame_len,
  output logic        crc_ok,
  output logic        frame_err,
  output logic        busy
);

  localparam logic [10:0] MAX_LEN_C = 11'(MAX_LEN);
  localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);

  state_e      state_q, state_d;
  logic [3:0]  low_q, low_d;
  logic        nib_hi_q, nib_hi_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic        oversize_q, oversize_d;
  logic [7:0]  byte_q, byte_d;
  logic        byte_valid_q, byte_valid_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic [10:0] frame_len_q, frame_len_d;
  logic        crc_ok_q, crc_ok_d;
  logic        frame_err_q, frame_err_d;
  logic        crc_match;

`ifdef MII_FRAME_RX_CRC_CHECK_EN
  logic [31:0] crc_val;
  logic        crc_clr;

  assign crc_clr = (state_q == PREAMBLE) && mii_dv && (mii_data == SFD_NIB);

  eth_crc32 u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (crc_clr),
    .en     (byte_valid_d),
    .data_i ({mii_data, low_q}),
    .crc_o  (crc_val)
  );

  // The shift-right register holds the residue bit-reversed relative to CRC_RESIDUE.
  assign crc_match = (bitrev32(crc_val) == CRC_RESIDUE);
`else
  assign crc_match = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    low_d        = low_q;
    nib_hi_d     = nib_hi_q;
    byte_cnt_d   = byte_cnt_q;
    oversize_d   = oversize_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    sof_d        = 1'b0;
    eof_d        = 1'b0;
    frame_len_d  = frame_len_q;
    crc_ok_d     = crc_ok_q;
    frame_err_d  = frame_err_q;
    case (state_q)
      IDLE: begin
        oversize_d = 1'b0;
        if (mii_dv) state_d = (mii_data == PREAMBLE_NIB) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!mii_dv) begin
          state_d = IDLE;
        end else if (mii_data == SFD_NIB) begin
          state_d    = DATA;
          nib_hi_d   = 1'b0;
          byte_cnt_d = '0;
        end else if (mii_data != PREAMBLE_NIB) begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (!mii_dv) begin
          state_d     = IDLE;
          eof_d       = 1'b1;
          frame_len_d = byte_cnt_q;
          crc_ok_d    = crc_match;
          frame_err_d = nib_hi_q || (byte_cnt_q < MIN_LEN_C);
        end else if (!nib_hi_q) begin
          low_d    = mii_data;
          nib_hi_d = 1'b1;
        end else begin
          nib_hi_d = 1'b0;
          if (byte_cnt_q == MAX_LEN_C) begin
            // Byte MAX_LEN+1: suppress it and everything after, count stays saturated.
            state_d    = DROP;
            oversize_d = 1'b1;
          end else begin
            byte_d       = {mii_data, low_q};
            byte_valid_d = 1'b1;
            sof_d        = (byte_cnt_q == '0);
            byte_cnt_d   = byte_cnt_q + 11'd1;
          end
        end
      end
      DROP: begin
        if (!mii_dv) begin
          state_d    = IDLE;
          oversize_d = 1'b0;
          if (oversize_q) begin
            eof_d       = 1'b1;
            frame_len_d = byte_cnt_q;
            crc_ok_d    = crc_match;
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      low_q        <= '0;
      nib_hi_q     <= 1'b0;
      byte_cnt_q   <= '0;
      oversize_q   <= 1'b0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      frame_len_q  <= '0;
      crc_ok_q     <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      low_q        <= low_d;
      nib_hi_q     <= nib_hi_d;
      byte_cnt_q   <= byte_cnt_d;
      oversize_q   <= oversize_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      frame_len_q  <= frame_len_d;
      crc_ok_q     <= crc_ok_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_o     = byte_q;
  assign byte_valid = byte_valid_q;
  assign sof        = sof_q;
  assign eof        = eof_q;
  assign frame_len  = frame_len_q;
  assign crc_ok     = crc_ok_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mii_frame_rx.sv
// tb/tb_mii_frame_rx.sv - directed self-checking bench for mii_frame_rx
module tb_mii_frame_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        mii_dv;
  logic [3:0]  mii_data;
  logic [7:0]  byte_o;
  logic        byte_valid, sof, eof, crc_ok, frame_err, busy;
  logic [10:0] frame_len;

  mii_frame_rx #(.MAX_LEN(1518), .MIN_LEN(64)) dut (
    .clk(clk), .rst(rst), .mii_dv(mii_dv), .mii_data(mii_data),
    .byte_o(byte_o), .byte_valid(byte_valid), .sof(sof), .eof(eof),
    .frame_len(frame_len), .crc_ok(crc_ok), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int bv_cnt = 0, sof_cnt = 0, eof_cnt = 0, sof_idx = -1;
  logic [7:0]  rx_q[$];
  logic [10:0] last_len;
  logic        last_ok, last_err;
  logic [7:0]  bq[$];
  logic [3:0]  nq[$];

`ifdef MII_FRAME_RX_CRC_CHECK_EN
  localparam logic CORRUPT_OK = 1'b0;
`else
  localparam logic CORRUPT_OK = 1'b1;
`endif

  always @(negedge clk) begin
    if (byte_valid) begin
      bv_cnt++;
      rx_q.push_back(byte_o);
    end
    if (sof) begin
      sof_cnt++;
      sof_idx = byte_valid ? rx_q.size() - 1 : -2;
    end
    if (eof) begin
      eof_cnt++;
      last_len = frame_len;
      last_ok  = crc_ok;
      last_err = frame_err;
    end
  end

  task automatic build_bytes(input int n, input bit with_fcs);
    logic [31:0] c;
    bq.delete();
    for (int i = 0; i < n; i++) bq.push_back(8'(i));
    if (with_fcs) begin
      c = 32'hFFFFFFFF;
      foreach (bq[i]) begin
        c = c ^ {24'h0, bq[i]};
        for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      c = ~c;
      bq.push_back(c[7:0]);
      bq.push_back(c[15:8]);
      bq.push_back(c[23:16]);
      bq.push_back(c[31:24]);
    end
  endtask

  task automatic make_nq();
    nq.delete();
    for (int i = 0; i < 15; i++) nq.push_back(4'h5);
    nq.push_back(4'hD);
    foreach (bq[i]) begin
      nq.push_back(bq[i][3:0]);
      nq.push_back(bq[i][7:4]);
    end
  endtask

  task automatic drive_nq();
    foreach (nq[k]) begin
      @(negedge clk);
      mii_dv   = 1'b1;
      mii_data = nq[k];
    end
    @(negedge clk);
    mii_dv   = 1'b0;
    mii_data = 4'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mii_dv = 1'b0;
    mii_data = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({byte_o, byte_valid, sof, eof} !== 11'h0) begin
      failures++;
      $display("FAIL reset_bytes: got %h expected 0", {byte_o, byte_valid, sof, eof});
    end
    checks++;
    if ({frame_len, crc_ok, frame_err, busy} !== 14'h0) begin
      failures++;
      $display("FAIL reset_status: got %h expected 0", {frame_len, crc_ok, frame_err, busy});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_good_frame();
    int bv0, eof0, sof0, base, bad;
    bv0 = bv_cnt; eof0 = eof_cnt; sof0 = sof_cnt; base = rx_q.size(); bad = 0;
    build_bytes(60, 1'b1);
    make_nq();
    drive_nq();
    repeat (4) @(negedge clk);
    checks++;
    if (bv_cnt - bv0 != 64) begin
      failures++; $display("FAIL good_bv: got %0d expected 64", bv_cnt - bv0);
    end
    for (int i = 0; i < 64 && base + i < rx_q.size(); i++) if (rx_q[base+i] !== bq[i]) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL good_bytes: got %0d wrong bytes expected 0", bad);
    end
    checks++;
    if (sof_cnt - sof0 != 1 || sof_idx != base) begin
      failures++; $display("FAIL good_sof: got count %0d at %0d expected 1 at %0d", sof_cnt - sof0, sof_idx, base);
    end
    checks++;
    if (eof_cnt - eof0 != 1) begin
      failures++; $display("FAIL good_eof: got %0d expected 1", eof_cnt - eof0);
    end
    checks++;
    if (last_len !== 11'd64 || last_ok !== 1'b1 || last_err !== 1'b0) begin
      failures++; $display("FAIL good_status: got len=%0d ok=%0d err=%0d expected 64 1 0", last_len, last_ok, last_err);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL good_busy: got %0d expected 0", busy);
    end
  endtask

  task automatic test_corrupt_frame();
    build_bytes(60, 1'b1);
    bq[10] = bq[10] ^ 8'h01;
    make_nq();
    drive_nq();
    repeat (4) @(negedge clk);
    checks++;
    if (last_len !== 11'd64 || last_ok !== CORRUPT_OK || last_err !== 1'b0) begin
      failures++; $display("FAIL corrupt_status: got len=%0d ok=%0d err=%0d expected 64 %0d 0", last_len, last_ok, last_err, CORRUPT_OK);
    end
  endtask

  task automatic test_odd_nibbles();
    int eof0;
    eof0 = eof_cnt;
    build_bytes(60, 1'b1);
    make_nq();
    nq.push_back(4'hA);
    drive_nq();
    repeat (4) @(negedge clk);
    checks++;
    if (eof_cnt - eof0 != 1 || last_len !== 11'd64 || last_err !== 1'b1) begin
      failures++; $display("FAIL odd_nibbles: got eof=%0d len=%0d err=%0d expected 1 64 1", eof_cnt - eof0, last_len, last_err);
    end
  endtask

  task automatic test_runt();
    build_bytes(59, 1'b1);
    make_nq();
    drive_nq();
    repeat (4) @(negedge clk);
    checks++;
    if (last_len !== 11'd63 || last_err !== 1'b1) begin
      failures++; $display("FAIL runt: got len=%0d err=%0d expected 63 1", last_len, last_err);
    end
  endtask

  task automatic test_oversize();
    int bv0, eof0;
    bv0 = bv_cnt; eof0 = eof_cnt;
    build_bytes(1519, 1'b0);
    make_nq();
    drive_nq();
    repeat (4) @(negedge clk);
    checks++;
    if (bv_cnt - bv0 != 1518) begin
      failures++; $display("FAIL oversize_bv: got %0d expected 1518", bv_cnt - bv0);
    end
    checks++;
    if (eof_cnt - eof0 != 1 || last_len !== 11'd1518 || last_err !== 1'b1) begin
      failures++; $display("FAIL oversize_status: got eof=%0d len=%0d err=%0d expected 1 1518 1", eof_cnt - eof0, last_len, last_err);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL oversize_busy: got %0d expected 0", busy);
    end
  endtask

  task automatic test_bad_preamble();
    int bv0, eof0;
    bv0 = bv_cnt; eof0 = eof_cnt;
    nq.delete();
    nq.push_back(4'h5); nq.push_back(4'h5); nq.push_back(4'h5);
    nq.push_back(4'h3); nq.push_back(4'h5); nq.push_back(4'h5);
    drive_nq();
    build_bytes(60, 1'b1);
    make_nq();
    drive_nq();
    repeat (4) @(negedge clk);
    checks++;
    if (bv_cnt - bv0 != 64 || eof_cnt - eof0 != 1) begin
      failures++; $display("FAIL bad_preamble_counts: got bv=%0d eof=%0d expected 64 1", bv_cnt - bv0, eof_cnt - eof0);
    end
    checks++;
    if (last_len !== 11'd64 || last_ok !== 1'b1 || last_err !== 1'b0) begin
      failures++; $display("FAIL bad_preamble_next: got len=%0d ok=%0d err=%0d expected 64 1 0", last_len, last_ok, last_err);
    end
  endtask

  task automatic test_back_to_back();
    int bv0, eof0, sof0;
    bv0 = bv_cnt; eof0 = eof_cnt; sof0 = sof_cnt;
    build_bytes(60, 1'b1);
    make_nq();
    drive_nq();
    drive_nq();
    repeat (4) @(negedge clk);
    checks++;
    if (bv_cnt - bv0 != 128 || eof_cnt - eof0 != 2 || sof_cnt - sof0 != 2) begin
      failures++; $display("FAIL back_to_back: got bv=%0d eof=%0d sof=%0d expected 128 2 2", bv_cnt - bv0, eof_cnt - eof0, sof_cnt - sof0);
    end
    checks++;
    if (last_len !== 11'd64 || last_ok !== 1'b1 || last_err !== 1'b0) begin
      failures++; $display("FAIL back_to_back_status: got len=%0d ok=%0d err=%0d expected 64 1 0", last_len, last_ok, last_err);
    end
  endtask

  task automatic test_reset_mid_frame();
    int bv0, eof0, bv_pre;
    bv0 = bv_cnt; eof0 = eof_cnt; bv_pre = 0;
    build_bytes(41, 1'b0);
    make_nq();
    for (int k = 0; k < nq.size(); k++) begin
      @(negedge clk);
      mii_dv   = 1'b1;
      mii_data = nq[k];
      if (k == 16 + 40) begin
        rst = 1'b1;
        #1;
        bv_pre = bv_cnt - bv0;
        bv0 = bv_cnt; eof0 = eof_cnt;
        checks++;
        if ({byte_o, byte_valid, sof, eof, frame_len, crc_ok, frame_err, busy} !== 25'h0) begin
          failures++; $display("FAIL mid_reset_outputs: got %h expected 0", {byte_o, byte_valid, sof, eof, frame_len, crc_ok, frame_err, busy});
        end
      end else begin
        rst = 1'b0;
      end
    end
    @(negedge clk);
    mii_dv = 1'b0;
    mii_data = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (bv_pre != 20) begin
      failures++; $display("FAIL mid_reset_pre: got %0d bytes expected 20", bv_pre);
    end
    checks++;
    if (bv_cnt != bv0 || eof_cnt != eof0) begin
      failures++; $display("FAIL mid_reset_ignored: got bv=%0d eof=%0d expected 0 0", bv_cnt - bv0, eof_cnt - eof0);
    end
    test_good_frame();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_corrupt_frame();
    test_odd_nibbles();
    test_runt();
    test_oversize();
    test_bad_preamble();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mii_frame_rx.md
MII_FRAME_RX -- requirements
Module: mii_frame_rx

Interface
REQ-001 Parameter MAX_LEN, default 1518: longest accepted frame in bytes, including FCS.
REQ-002 Parameter MIN_LEN, default 64: shortest accepted frame in bytes, including FCS.
REQ-003 clk  input  1  sole clock, MII nibble clock; all inputs sampled on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 mii_dv  input  1  MII data valid (TX_EN of the transmitting MAC).
REQ-006 mii_data  input  4  MII nibble, low nibble of each byte first.
REQ-007 byte_o  output  8  received byte, {high nibble, low nibble}.
REQ-008 byte_valid  output  1  one-cycle strobe qualifying byte_o.
REQ-009 sof  output  1  strobe coincident with the first byte_valid of a frame.
REQ-010 eof  output  1  one-cycle end-of-frame strobe.
REQ-011 frame_len  output  11  byte count of the last frame; valid from eof until next sof.
REQ-012 crc_ok  output  1  FCS check result; valid from eof until next sof.
REQ-013 frame_err  output  1  alignment/runt/oversize flag; valid from eof until next sof.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, PREAMBLE, DATA, DROP.
REQ-016 IDLE: mii_dv=1 with nibble 0x5 -> PREAMBLE; mii_dv=1 with any other nibble -> DROP; otherwise stay.
REQ-017 PREAMBLE: nibble 0x5 -> stay; nibble 0xD -> DATA; any other nibble -> DROP; mii_dv=0 -> IDLE with no eof.
REQ-018 DATA, byte assembly: first nibble latched as low; second completes the byte.
REQ-019 DATA, byte output: byte_valid=1 and byte_o driven in the cycle after the high nibble is sampled (latency 1).
REQ-020 DATA, byte counting: each completed byte increments the byte counter.
REQ-021 DATA end: mii_dv sampled 0 -> eof=1 next cycle, frame_len/crc_ok/frame_err updated in that cycle, state -> IDLE.
REQ-022 frame_err=1 on any of: odd nibble count at end of frame; frame_len<MIN_LEN; byte count reaching MAX_LEN+1.
REQ-023 Oversize: on reaching byte MAX_LEN+1, that byte and all later bytes are suppressed, frame_len saturates at MAX_LEN, state -> DROP.
REQ-024 DROP: wait for mii_dv=0; produces eof only if entered from DATA.
REQ-025 Back-to-back frames: mii_dv reasserted in the cycle immediately after deassertion is decoded as a new frame; the eof of the previous frame is not lost.
REQ-026 Nibble counter and byte counter clear on entry to DATA.

Reset
REQ-027 On rst: state IDLE; byte_o=0, byte_valid=0, sof=0, eof=0, frame_len=0, crc_ok=0, frame_err=0, busy=0.
REQ-028 Reset mid-frame: the remainder of the frame is decoded from IDLE per REQ-016 (normally -> DROP); no partial eof is generated.

Configuration
REQ-029 Macro MII_FRAME_RX_CRC_CHECK_EN defined: CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF) runs over all bytes including FCS; crc_ok=1 when the register equals residue 0xC704DD7B.
REQ-030 Macro MII_FRAME_RX_CRC_CHECK_EN undefined: no CRC logic; crc_ok=1 at every eof; reset value still 0.

Structure
REQ-031 Shared package mii_frame_pkg holds: state encoding; PREAMBLE_NIB=4'h5; SFD_NIB=4'hD; CRC_POLY_REFL=32'hEDB88320; CRC_INIT=32'hFFFFFFFF; CRC_RESIDUE=32'hC704DD7B.
REQ-032 Sub-module eth_crc32: byte-wide registered CRC with clear, enable and byte inputs; instantiated only under MII_FRAME_RX_CRC_CHECK_EN.

Verification
REQ-033 Good frame: 7x0x55, 0xD5, bytes 0x00..0x3B, correct FCS -> 64 byte_valid pulses, sof with first, one eof, frame_len=64, crc_ok=1, frame_err=0.
REQ-034 Corrupted frame: same frame with byte 10 bit 0 flipped -> frame_len=64, crc_ok=0 (1 if macro undefined), frame_err=0.
REQ-035 Odd nibbles: mii_dv drops after 129 data nibbles -> frame_len=64, frame_err=1.
REQ-036 Oversize: 1519-byte frame -> exactly 1518 byte_valid pulses, frame_len=1518, frame_err=1.
REQ-037 Bad preamble: nibble 0x3 in preamble -> no byte_valid, no eof; next frame after 1 idle cycle received per REQ-033.
REQ-038 Reset mid-frame: rst pulsed at byte 20 -> all outputs 0, remainder ignored; following good frame received per REQ-033.
